debounce_pulse: RTL
===================

# debounce_pulse

Conditions a raw, asynchronous push-button or switch input into a clean debounced level and a single-cycle enable pulse per confirmed press. It sits directly upstream of the n-bit counter: `pulse_out` drives the counter's `en` (or `load`) input so that each physical press advances the counter exactly once. It contains a 2-flop synchronizer, a debounce confirmation FSM with a stability counter, and an optional auto-repeat timer.

## Interface

Parameters:
- `DEBOUNCE_CYCLES`, default 16: consecutive stable cycles required to accept a level change; legal range ≥ 1.
- `REPEAT_CYCLES`, default 64: auto-repeat period in cycles while held; legal range ≥ 2; used only with the macro defined.

Ports:
- `clk`  input  1  single clock for all logic.
- `reset`  input  1  synchronous, active-high reset.
- `btn_in`  input  1  raw asynchronous button level; 1 = pressed.
- `level_out`  output  1  debounced button level.
- `pulse_out`  output  1  one-cycle pulse per accepted press (plus repeats when enabled).

## Operation

- Synchronizer: `s1 <= btn_in`, `s2 <= s1`. The FSM uses only `s2`.
- FSM states:
  - `IDLE`: level 0.
  - `CONFIRM_PRESS`: level 0, counting.
  - `PRESSED`: level 1.
  - `CONFIRM_RELEASE`: level 1, counting.
- Stability counter `cnt` is `$clog2(DEBOUNCE_CYCLES+1)` bits wide and saturates at `DEBOUNCE_CYCLES`.
- `IDLE`:
  - `s2=1` → `CONFIRM_PRESS`, `cnt=1`.
  - If `DEBOUNCE_CYCLES==1`, go directly to `PRESSED` with a pulse.
- `CONFIRM_PRESS`:
  - `s2=0` → `IDLE`, `cnt=0`, no pulse (glitch rejected).
  - `s2=1` and `cnt==DEBOUNCE_CYCLES-1` → `PRESSED`, `level_out<=1`, `pulse_out<=1` for one cycle.
  - Otherwise `cnt++`.
- `PRESSED`: `s2=0` → `CONFIRM_RELEASE`, `cnt=1` (same `DEBOUNCE_CYCLES==1` shortcut applies).
- `CONFIRM_RELEASE`:
  - `s2=1` → `PRESSED`, no pulse.
  - Accepted after `DEBOUNCE_CYCLES` consecutive 0s → `IDLE`, `level_out<=0`.
  - No pulse on release.
- `level_out` and `pulse_out` are registered outputs and are never combinational from `btn_in`.
- Glitches shorter than `DEBOUNCE_CYCLES` cycles, measured at `s2`, never change `level_out` and never pulse.

## Timing

- Reset (synchronous, active-high):
  - `s1`, `s2`, `cnt`, and the repeat counter clear to 0.
  - State returns to `IDLE`.
  - `level_out=0`, `pulse_out=0`.
  - Reset overrides every other event in the same cycle.
- Press latency: let edge 0 be the first edge sampling `btn_in=1`. If `btn_in` is sampled 1 at edges 0..D-1 (D = `DEBOUNCE_CYCLES`), then `level_out` and `pulse_out` are 1 immediately after edge D+1. `pulse_out` returns to 0 after edge D+2.
- Release latency: symmetric. `level_out` falls after edge D+1, counted from the first edge sampling 0.
- Reset mid-confirmation aborts the confirmation with no pulse.
- If `btn_in` is still held when reset deasserts, detection restarts from `IDLE`. One fresh pulse is issued after full latency.
- `pulse_out` is never asserted in two consecutive cycles, with or without repeat.

## Configuration

- Macro: `DEBOUNCE_PULSE_REPEAT_EN`.
- Defined:
  - In `PRESSED`, a repeat counter starts at 0 on entry and increments each cycle.
  - On reaching `REPEAT_CYCLES-1`, `pulse_out<=1` and the counter reloads to 0.
  - Repeat pulses therefore occur every `REPEAT_CYCLES` cycles after the initial pulse.
  - The counter holds at 0 in all other states, including `CONFIRM_RELEASE`.
  - Bouncing back from `CONFIRM_RELEASE` to `PRESSED` restarts the count from 0.
- Undefined: the repeat counter and the `REPEAT_CYCLES` logic are absent, and exactly one pulse is issued per accepted press.

## Structure

- Package `debounce_pkg`:
  - `typedef enum logic [1:0] {IDLE, CONFIRM_PRESS, PRESSED, CONFIRM_RELEASE} db_state_t`.
  - Width helper constant function for counter widths.
- Sub-module `sync_2ff` (parameterless single-bit 2-flop synchronizer with synchronous active-high reset), instantiated once; reusable by other input blocks.
- The FSM and counters stay in `debounce_pulse`.

## Test plan

- Reset behaviour, D=4: hold `reset`=1 for 3 cycles with `btn_in`=1 → `level_out`=0 and `pulse_out`=0 throughout. After release, exactly one pulse appears after edge 5.
- Clean press, D=4: `btn_in` 0→1 held 20 cycles → `level_out` and `pulse_out` both 1 after edge 5. `pulse_out` is low after edge 6. Total pulses = 1 (macro undefined).
- Glitch rejection, D=4:
  - 3-cycle high blips separated by 1-cycle lows → `level_out` stays 0 and there are 0 pulses.
  - Bounce during release (1-cycle high) → `level_out` stays 1 until 4 clean zeros, with no extra pulse.
- Counter integration, D=4: `pulse_out` connected to a 4-bit counter's `en`; 17 clean presses → count = 1 (wrap from 15 to 0).
- Repeat, D=4, R=8, macro defined: hold for 40 cycles after acceptance → pulses at acceptance +8, +16, +24, +32 (5 total). After release, no further pulses.
- Reset mid-confirmation: assert `reset` when `cnt`=2 in `CONFIRM_PRESS` → no pulse, state `IDLE`. The held button then yields one pulse D+2 edges after reset deasserts.

Source files
------------

// File: rtl/debounce_pkg.sv
// Shared types and width helpers for the button debouncer.
package debounce_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CONFIRM_PRESS,
        PRESSED,
        CONFIRM_RELEASE
    } db_state_t;

    // Bits needed to hold values 0..max_val (at least one bit).
    function automatic int db_width(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchronizer with synchronous active-high reset.
module sync_2ff (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic s1;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1 <= 1'b0;
            q  <= 1'b0;
        end else begin
            s1 <= d;
            q  <= s1;
        end
    end

endmodule

// File: rtl/debounce_pulse.sv
// Debounces a raw button into a clean level plus one enable pulse per press.
// Define DEBOUNCE_PULSE_REPEAT_EN to add an auto-repeat pulse while held.
module debounce_pulse
    import debounce_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int REPEAT_CYCLES   = 64
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_in,
    output logic level_out,
    output logic pulse_out
);

    localparam int CW = db_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(DEBOUNCE_CYCLES);
    localparam bit SINGLE = (DEBOUNCE_CYCLES == 1);

    logic            s2;
    db_state_t       state, state_nxt;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic            pulse_nxt;
    logic            level_nxt;

    sync_2ff u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (btn_in),
        .q     (s2)
    );

`ifdef DEBOUNCE_PULSE_REPEAT_EN
    localparam int RW = db_width(REPEAT_CYCLES - 1);
    localparam logic [RW-1:0] RPT_LAST = RW'(REPEAT_CYCLES - 1);

    logic [RW-1:0] rcnt, rcnt_nxt;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            level_out <= 1'b0;
            pulse_out <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            level_out <= level_nxt;
            pulse_out <= pulse_nxt;
        end
    end

`ifdef DEBOUNCE_PULSE_REPEAT_EN
    always_ff @(posedge clk) begin
        if (reset) rcnt <= '0;
        else       rcnt <= rcnt_nxt;
    end
`endif

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        pulse_nxt = 1'b0;
        case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (s2) begin
                    if (SINGLE) begin
                        state_nxt = PRESSED;
                        pulse_nxt = 1'b1;
                    end else begin
                        state_nxt = CONFIRM_PRESS;
                        cnt_nxt   = CNT_ONE;
                    end
                end
            end
            CONFIRM_PRESS: begin
                if (!s2) begin
                    // glitch rejected, start over
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = PRESSED;
                    cnt_nxt   = '0;
                    pulse_nxt = 1'b1;
                end else if (cnt < CNT_MAX) begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
            PRESSED: begin
                cnt_nxt = '0;
                if (!s2) begin
                    if (SINGLE) begin
                        state_nxt = IDLE;
                    end else begin
                        state_nxt = CONFIRM_RELEASE;
                        cnt_nxt   = CNT_ONE;
                    end
                end
            end
            CONFIRM_RELEASE: begin
                if (s2) begin
                    state_nxt = PRESSED;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else if (cnt < CNT_MAX) begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase

`ifdef DEBOUNCE_PULSE_REPEAT_EN
        // Repeat timer runs only while the press stays accepted; any exit or
        // bounce-back from release confirmation restarts it from zero.
        rcnt_nxt = '0;
        if (state == PRESSED && state_nxt == PRESSED) begin
            if (rcnt == RPT_LAST) begin
                pulse_nxt = 1'b1;
            end else begin
                rcnt_nxt = rcnt + RW'(1);
            end
        end
`endif

        level_nxt = (state_nxt == PRESSED) || (state_nxt == CONFIRM_RELEASE);
    end

endmodule
